// File: rtl/stc_pkg.sv
// Shared types and helpers for the spike-time-coding pipeline.
// Holds the encoder state enum and the spike validity check used by pulse_encoder.
package stc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } enc_state_e;

  // A spike at time t occupying span phases is representable only if it ends
  // inside the gamma cycle; anything later is treated as "infinity" (no spike).
  function automatic logic spike_fits(input int unsigned t,
                                      input int unsigned span,
                                      input int unsigned gamma_w);
    return (t + span) <= gamma_w;
  endfunction

endpackage

// File: rtl/pulse_encoder_if.sv
// Spike-time input handshake for pulse_encoder.
//   in_valid : producer offers in_value
//   in_value : spike time t for a future gamma cycle
//   in_ready : encoder accepts in_value this cycle (transfer = valid && ready)
interface pulse_encoder_if #(
  parameter int unsigned VAL_W = 5
);

  logic             in_valid;
  logic [VAL_W-1:0] in_value;
  logic             in_ready;

  modport master (
    output in_valid,
    output in_value,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_value,
    output in_ready
  );

endinterface

// File: rtl/pulse_encoder_gamma_counter.sv
// Gamma-cycle phase counter: counts 0..GAMMA_CYCLE_WIDTH-1 while running,
// holds 0 when stopped, and strobes gamma_start_o on every phase-0 cycle.
//   aclk, grst      : clock, asynchronous active-high reset
//   run_i           : encoder is running (RUN or DRAIN) this cycle
//   run_nxt_i       : encoder will be running next cycle
//   phase_o         : registered phase index
//   gamma_start_o   : registered phase-0 strobe
//   wrap_c_o        : combinational, last phase of a running gamma cycle
//   phase_nxt_c_o   : combinational, phase value for the next cycle
module gamma_counter #(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PH_W              = 4
) (
  input  logic            aclk,
  input  logic            grst,
  input  logic            run_i,
  input  logic            run_nxt_i,
  output logic [PH_W-1:0] phase_o,
  output logic            gamma_start_o,
  output logic            wrap_c_o,
  output logic [PH_W-1:0] phase_nxt_c_o
);

  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(GAMMA_CYCLE_WIDTH - 1);

  logic [PH_W-1:0] phase_q, phase_d;
  logic            gstart_q, gstart_d;
  logic            wrap_c;

  // Next phase: advance while running, restart at 0 on wrap, start, or stop.
  always_comb begin
    wrap_c   = run_i && (phase_q == LAST_PHASE);
    phase_d  = '0;
    if (run_i && run_nxt_i && !wrap_c) begin
      phase_d = phase_q + PH_W'(1);
    end
    gstart_d = run_nxt_i && (phase_d == '0);
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      phase_q  <= '0;
      gstart_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      gstart_q <= gstart_d;
    end
  end

  assign phase_o       = phase_q;
  assign gamma_start_o = gstart_q;
  assign wrap_c_o      = wrap_c;
  assign phase_nxt_c_o = phase_d;

endmodule

// File: rtl/pulse_encoder.sv
// Temporal spike encoder: turns a spike time t into a pulse on y during the
// gamma cycle after the one in which t was accepted.
//   aclk, grst   : clock, asynchronous active-high reset
//   en           : run request (1 = generate gamma cycles)
//   in_if        : slave handshake carrying spike time t (in_valid/in_value/in_ready)
//   y            : registered encoded spike
//   gamma_start  : registered phase-0 strobe (downstream latch reset)
//   gamma_phase  : current phase 0..GAMMA_CYCLE_WIDTH-1
// Build option: define ENC_EDGE_MODE_EN for step encoding (y rises at t and
// stays high to the end of the gamma cycle); otherwise y is a PULSE_WIDTH pulse.
module pulse_encoder
  import stc_pkg::*;
#(
  parameter  int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter  int unsigned PULSE_WIDTH       = 8,
  localparam int unsigned VAL_W             = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic             aclk,
  input  logic             grst,
  input  logic             en,
  pulse_encoder_if.slave   in_if,
  output logic             y,
  output logic             gamma_start,
  output logic [VAL_W-2:0] gamma_phase
);

  localparam int unsigned PH_W = VAL_W - 1;
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(GAMMA_CYCLE_WIDTH - 1);

`ifdef ENC_EDGE_MODE_EN
  // A step only needs its first phase inside the cycle.
  localparam int unsigned SPAN = 1;
`else
  localparam int unsigned SPAN = PULSE_WIDTH;
`endif

  enc_state_e       state_q, state_d;
  logic             pend_v_q, pend_v_d;
  logic [VAL_W-1:0] pend_val_q, pend_val_d;
  logic             act_v_q, act_v_d;
  logic [VAL_W-1:0] act_val_q, act_val_d;
  logic             y_q, y_d;
  logic             in_ready_q, in_ready_d;

  logic             wrap_c;
  logic             xfer_c;
  logic [PH_W-1:0]  phase_nxt_c;
  logic [PH_W-1:0]  phase_c;
  logic             gstart_c;
  logic [31:0]      ph_c, t_c;
  logic             in_win_c;

  gamma_counter #(
    .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
    .PH_W              (PH_W)
  ) u_gamma_counter (
    .aclk          (aclk),
    .grst          (grst),
    .run_i         (state_q != IDLE),
    .run_nxt_i     (state_d != IDLE),
    .phase_o       (phase_c),
    .gamma_start_o (gstart_c),
    .wrap_c_o      (wrap_c),
    .phase_nxt_c_o (phase_nxt_c)
  );

  assign xfer_c = in_if.in_valid && in_ready_q;

  // Next state, pending/active registers and registered outputs.
  always_comb begin
    state_d    = state_q;
    pend_v_d   = pend_v_q;
    pend_val_d = pend_val_q;
    act_v_d    = act_v_q;
    act_val_d  = act_val_q;
    ph_c       = '0;
    t_c        = '0;
    in_win_c   = 1'b0;
    y_d        = 1'b0;
    in_ready_d = 1'b1;

    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en) begin
          state_d = RUN;
        end else if (wrap_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Only a wrap taken in RUN promotes pending; any DRAIN wrap (even one that
    // resumes RUN) just closes the cycle with no spike queued for the next one.
    if (wrap_c) begin
      if (state_q == RUN) begin
        act_v_d   = pend_v_q && spike_fits(32'(pend_val_q), SPAN, GAMMA_CYCLE_WIDTH);
        act_val_d = pend_val_q;
        pend_v_d  = 1'b0;
      end else begin
        act_v_d   = 1'b0;
      end
    end

    // A transfer lands after the promotion, so it waits a full gamma cycle.
    if (xfer_c) begin
      pend_v_d   = 1'b1;
      pend_val_d = in_if.in_value;
    end

    // y is decided from next-cycle phase/active so it changes only at the edge.
    ph_c = 32'(phase_nxt_c);
    t_c  = 32'(act_val_d);
`ifdef ENC_EDGE_MODE_EN
    in_win_c = (ph_c >= t_c);
`else
    in_win_c = (ph_c >= t_c) && (ph_c < (t_c + 32'(PULSE_WIDTH)));
`endif
    y_d = act_v_d && (state_d != IDLE) && in_win_c;

    // Ready next cycle if pending is free or that cycle is a RUN wrap.
    in_ready_d = !pend_v_d || ((state_d == RUN) && (phase_nxt_c == LAST_PHASE));
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      state_q    <= IDLE;
      pend_v_q   <= 1'b0;
      pend_val_q <= '0;
      act_v_q    <= 1'b0;
      act_val_q  <= '0;
      y_q        <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pend_v_q   <= pend_v_d;
      pend_val_q <= pend_val_d;
      act_v_q    <= act_v_d;
      act_val_q  <= act_val_d;
      y_q        <= y_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign y              = y_q;
  assign gamma_start    = gstart_c;
  assign gamma_phase    = phase_c;

endmodule

// File: tb/tb_pulse_encoder.sv
// Self-checking bench for pulse_encoder (GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=8).
// Accepted spike times push the expected y pattern of the following gamma
// cycle into a scoreboard; each observed gamma cycle pops and compares.
`timescale 1ns/1ps
module tb_pulse_encoder;

  localparam int unsigned G    = 16;
  localparam int unsigned PW   = 8;
  localparam int unsigned VW   = $clog2(G) + 1;
  localparam int unsigned PH_W = VW - 1;

  logic            aclk = 1'b0;
  logic            grst;
  logic            en;
  logic            y;
  logic            gamma_start;
  logic [PH_W-1:0] gamma_phase;

  pulse_encoder_if #(.VAL_W(VW)) in_if ();

  pulse_encoder #(
    .GAMMA_CYCLE_WIDTH (G),
    .PULSE_WIDTH       (PW)
  ) dut (
    .aclk        (aclk),
    .grst        (grst),
    .en          (en),
    .in_if       (in_if.slave),
    .y           (y),
    .gamma_start (gamma_start),
    .gamma_phase (gamma_phase)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [G-1:0] sb_q[$];

  // Expected y over one gamma cycle for spike time t.
  function automatic logic [G-1:0] exp_mask(input int unsigned t);
    logic [G-1:0] m;
    m = '0;
`ifdef ENC_EDGE_MODE_EN
    if (t <= G - 1) begin
      for (int p = int'(t); p < int'(G); p++) m[p] = 1'b1;
    end
`else
    if (t + PW <= G) begin
      for (int p = int'(t); p < int'(t + PW); p++) m[p] = 1'b1;
    end
`endif
    return m;
  endfunction

  // Present v until accepted; optionally record its expected pattern.
  task automatic offer(input int unsigned v, input bit push);
    in_if.in_valid = 1'b1;
    in_if.in_value = VW'(v);
    for (int i = 0; i < 40; i++) begin
      if (in_if.in_ready) begin
        @(negedge aclk);
        in_if.in_valid = 1'b0;
        if (push) sb_q.push_back(exp_mask(v));
        return;
      end
      @(negedge aclk);
    end
    in_if.in_valid = 1'b0;
    n_checks++;
    n_fail++;
    $display("FAIL offer_timeout: value %0d never accepted, in_ready required 1", v);
  endtask

  // Wait for the next phase-0 strobe and record y over the whole gamma cycle.
  task automatic collect(output logic [G-1:0] obs, output bit ok);
    obs = '0;
    ok  = 1'b0;
    for (int i = 0; i < int'(3 * G) && !gamma_start; i++) @(negedge aclk);
    if (!gamma_start) return;
    ok = 1'b1;
    for (int p = 0; p < int'(G); p++) begin
      if (p != 0) @(negedge aclk);
      obs[p] = y;
    end
  endtask

  task automatic test_reset;
    grst = 1'b1;
    en   = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_value = '0;
    repeat (3) @(negedge aclk);
    n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL reset_y: got %b want 0", y); end
    n_checks++; if (gamma_start !== 1'b0) begin n_fail++; $display("FAIL reset_gstart: got %b want 0", gamma_start); end
    n_checks++; if (gamma_phase !== '0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", gamma_phase); end
    n_checks++; if (in_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_if.in_ready); end
    grst = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_start;
    en = 1'b1;
    @(negedge aclk);
    n_checks++; if (gamma_start !== 1'b1) begin n_fail++; $display("FAIL start_gstart: got %b want 1", gamma_start); end
    n_checks++; if (gamma_phase !== '0) begin n_fail++; $display("FAIL start_phase: got %0d want 0", gamma_phase); end
  endtask

  task automatic test_pulse;
    logic [G-1:0] obs, exp;
    bit ok;
    offer(3, 1'b1);
    collect(obs, ok);
    exp = '0;
    if (sb_q.size() != 0) exp = sb_q.pop_front();
    n_checks++; if (!ok || obs !== exp) begin n_fail++; $display("FAIL pulse_t3: got %h want %h", obs, exp); end
    collect(obs, ok);
    exp = '0;
    if (sb_q.size() != 0) exp = sb_q.pop_front();
    n_checks++; if (!ok || obs !== exp) begin n_fail++; $display("FAIL pulse_empty: got %h want %h", obs, exp); end
  endtask

  task automatic test_boundary;
    int unsigned vals[5] = '{8, 9, 0, 15, 12};
    logic [G-1:0] obs, exp;
    bit ok;
    foreach (vals[k]) begin
      @(negedge aclk);
      offer(vals[k], 1'b1);
      collect(obs, ok);
      exp = '0;
      if (sb_q.size() != 0) exp = sb_q.pop_front();
      n_checks++;
      if (!ok || obs !== exp) begin
        n_fail++;
        $display("FAIL boundary_t%0d: got %h want %h", vals[k], obs, exp);
      end
    end
    @(negedge aclk);
    n_checks++;
    if (y !== 1'b0 || gamma_start !== 1'b1) begin
      n_fail++;
      $display("FAIL after_step: y=%b gstart=%b want y=0 gstart=1", y, gamma_start);
    end
  endtask

  task automatic test_back_to_back;
    logic [G-1:0] obs, exp;
    bit ok;
    offer(2, 1'b1);
    in_if.in_valid = 1'b1;
    in_if.in_value = VW'(5);
    repeat (4) @(negedge aclk);
    n_checks++; if (in_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", in_if.in_ready); end
    for (int i = 0; i < 20 && !in_if.in_ready; i++) @(negedge aclk);
    n_checks++;
    if (in_if.in_ready !== 1'b1 || gamma_phase !== PH_W'(G - 1)) begin
      n_fail++;
      $display("FAIL bp_ready_phase: ready=%b phase=%0d want ready=1 phase=%0d", in_if.in_ready, gamma_phase, G - 1);
    end
    @(negedge aclk);
    in_if.in_valid = 1'b0;
    sb_q.push_back(exp_mask(5));
    collect(obs, ok);
    exp = '0;
    if (sb_q.size() != 0) exp = sb_q.pop_front();
    n_checks++; if (!ok || obs !== exp) begin n_fail++; $display("FAIL bp_first: got %h want %h", obs, exp); end
    collect(obs, ok);
    exp = '0;
    if (sb_q.size() != 0) exp = sb_q.pop_front();
    n_checks++; if (!ok || obs !== exp) begin n_fail++; $display("FAIL bp_second: got %h want %h", obs, exp); end
  endtask

  task automatic test_drain;
    logic [G-1:0] obs, exp;
    bit ok;
    int n;
    @(negedge aclk);
    offer(4, 1'b1);
    for (int i = 0; i < 40 && gamma_phase != PH_W'(5); i++) @(negedge aclk);
    en = 1'b0;
    n = 0;
    while (n < 40 && gamma_phase != PH_W'(G - 1)) begin
      @(negedge aclk);
      n++;
    end
    n_checks++; if (n != 10) begin n_fail++; $display("FAIL drain_len: got %0d cycles want 10", n); end
    @(negedge aclk);
    n_checks++; if (gamma_phase !== '0) begin n_fail++; $display("FAIL drain_phase: got %0d want 0", gamma_phase); end
    n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL drain_y: got %b want 0", y); end
    n_checks++; if (gamma_start !== 1'b0) begin n_fail++; $display("FAIL drain_gstart: got %b want 0", gamma_start); end
    n_checks++; if (in_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_pend_kept: ready=%b want 0", in_if.in_ready); end
    repeat (3) @(negedge aclk);
    n_checks++;
    if (gamma_phase !== '0 || y !== 1'b0 || gamma_start !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: phase=%0d y=%b gstart=%b want 0 0 0", gamma_phase, y, gamma_start);
    end
    en = 1'b1;
    @(negedge aclk);
    collect(obs, ok);
    n_checks++; if (!ok || obs !== '0) begin n_fail++; $display("FAIL restart_empty: got %h want 0000", obs); end
    collect(obs, ok);
    exp = '0;
    if (sb_q.size() != 0) exp = sb_q.pop_front();
    n_checks++; if (!ok || obs !== exp) begin n_fail++; $display("FAIL restart_t4: got %h want %h", obs, exp); end
  endtask

  task automatic test_reset_mid;
    logic [G-1:0] obs;
    bit ok;
    @(negedge aclk);
    offer(3, 1'b0);
    for (int i = 0; i < 40 && !gamma_start; i++) @(negedge aclk);
    offer(7, 1'b0);
    repeat (5) @(negedge aclk);
    n_checks++;
    if (gamma_phase !== PH_W'(6) || y !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_spike: phase=%0d y=%b want phase=6 y=1", gamma_phase, y);
    end
    grst = 1'b1;
    en   = 1'b0;
    #1;
    n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL rst_async_y: got %b want 0", y); end
    n_checks++; if (in_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", in_if.in_ready); end
    n_checks++; if (gamma_phase !== '0) begin n_fail++; $display("FAIL rst_phase: got %0d want 0", gamma_phase); end
    @(negedge aclk);
    grst = 1'b0;
    @(negedge aclk);
    n_checks++;
    if (gamma_start !== 1'b0 || gamma_phase !== '0) begin
      n_fail++;
      $display("FAIL rst_idle: gstart=%b phase=%0d want 0 0", gamma_start, gamma_phase);
    end
    en = 1'b1;
    @(negedge aclk);
    collect(obs, ok);
    n_checks++; if (!ok || obs !== '0) begin n_fail++; $display("FAIL rst_discard1: got %h want 0000", obs); end
    collect(obs, ok);
    n_checks++; if (!ok || obs !== '0) begin n_fail++; $display("FAIL rst_discard2: got %h want 0000", obs); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pulse();
    test_boundary();
    test_back_to_back();
    test_drain();
    test_reset_mid();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: %0d entries, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pulse_encoder.md
PULSE_ENCODER -- requirements
Module: pulse_encoder

Interface
REQ-001 SHALL have parameter GAMMA_CYCLE_WIDTH, default 16, meaning aclk cycles per gamma cycle (>= 2).
REQ-002 SHALL have parameter PULSE_WIDTH, default 8, meaning spike pulse length in aclk cycles (1..GAMMA_CYCLE_WIDTH).
REQ-003 SHALL have localparam VAL_W = $clog2(GAMMA_CYCLE_WIDTH)+1, the spike-time value width.
REQ-004 aclk  input  1  clock; all state updates on rising edge.
REQ-005 grst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  run request; 1 = generate gamma cycles.
REQ-007 in_valid  input  1  in_value is offered.
REQ-008 in_value  input  VAL_W  spike time t for a future gamma cycle.
REQ-009 in_ready  output  1  encoder can accept in_value this cycle.
REQ-010 y  output  1  temporally encoded spike, feeding the downstream max/min stages.
REQ-011 gamma_start  output  1  one-cycle strobe at phase 0; drives downstream latch rst.
REQ-012 gamma_phase  output  VAL_W-1  current phase index 0..GAMMA_CYCLE_WIDTH-1.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN.
REQ-014 IDLE: phase held 0, y=0, gamma_start=0; en=1 -> RUN, with phase 0 on the next cycle and gamma_start=1 in that cycle.
REQ-015 RUN: phase increments each cycle, wrapping GAMMA_CYCLE_WIDTH-1 -> 0; gamma_start=1 exactly when phase=0.
REQ-016 RUN with en=0 -> DRAIN; DRAIN completes the current gamma cycle, then enters IDLE at the wrap instead of starting phase 0.
REQ-017 DRAIN with en=1 -> RUN; the phase sequence is uninterrupted.
REQ-018 SHALL hold a one-entry pending register (value + valid) and an active register (value + valid).
REQ-019 Transfer occurs when in_valid && in_ready; in_ready = !pending_valid || (wrap cycle in RUN).
REQ-020 At each wrap in RUN (phase GAMMA_CYCLE_WIDTH-1 -> 0), pending SHALL move to active and pending SHALL clear.
REQ-021 If pending is empty at the wrap, active SHALL become invalid (no spike, "infinity").
REQ-022 A transfer in the wrap cycle SHALL load pending after the move; the new value is emitted one gamma cycle later.
REQ-023 Latency: a value accepted in gamma cycle k SHALL be emitted in gamma cycle k+1.
REQ-024 A spike is valid iff t + PULSE_WIDTH <= GAMMA_CYCLE_WIDTH; otherwise it SHALL be treated as infinity (y stays 0).
REQ-025 y SHALL be registered, glitch-free, and 1 exactly on cycles with active valid and gamma_phase in [t, t+PULSE_WIDTH-1].
REQ-026 Transfers are accepted in IDLE and DRAIN (pending fills); the active register loads only at RUN wraps.
REQ-027 The last wrap of DRAIN SHALL clear active and leave pending untouched.

Reset
REQ-028 grst SHALL force: state IDLE, phase 0, pending and active invalid, y=0, gamma_start=0, in_ready=1.
REQ-029 grst asserted mid-spike SHALL drop y within the same cycle (asynchronous) and discard both registers.

Configuration
REQ-030 ENC_EDGE_MODE_EN defined: y SHALL rise at phase t and stay 1 through phase GAMMA_CYCLE_WIDTH-1 (step encoding); the validity rule becomes t <= GAMMA_CYCLE_WIDTH-1.
REQ-031 ENC_EDGE_MODE_EN undefined: pulse encoding per REQ-024/REQ-025.

Structure
REQ-032 Shared package stc_pkg SHALL hold the state enum (IDLE, RUN, DRAIN) and a spike_fits(t) function.
REQ-033 The phase counter with its wrap and gamma_start logic SHALL be sub-module gamma_counter.

Verification (GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=8)
REQ-034 After grst, en=1, value 3 accepted in cycle 0 -> y=1 at phases 3..10 of cycle 1, 0 otherwise.
REQ-035 Value 9 (9+8>16) -> y=0 for the whole following gamma cycle; value 8 -> y=1 at phases 8..15.
REQ-036 Pending full, in_valid held -> in_ready=0 until phase 15; then the value is accepted and the queued value goes active.
REQ-037 en dropped at phase 5 -> phases continue to 15, then IDLE; phase=0, y=0, no gamma_start.
REQ-038 grst pulsed at phase 6 while y=1 -> y=0 immediately, in_ready=1, state IDLE.
REQ-039 With ENC_EDGE_MODE_EN, value 12 -> y=1 at phases 12..15, 0 at the next phase 0.
